// File: rtl/dit_pkg.sv
// Shared constants, read-sequencer state encoding and the bit-reversal helper
// for the decimation-in-time frame controller.
package dit_pkg;

  localparam int DATLEN    = 12;
  localparam int VLEN      = 16;
  localparam int VLEN_LOG2 = 4;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_START     = 2'd1,
    RD_STREAM    = 2'd2,
    RD_WAIT_DONE = 2'd3
  } rd_state_e;

  function automatic logic [VLEN_LOG2-1:0] bitrev(input logic [VLEN_LOG2-1:0] a);
    logic [VLEN_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < VLEN_LOG2; i++) begin
      r[i] = a[VLEN_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dit_rd_seq.sv
// Read sequencer: waits for the oldest bank to fill, pulses fft_start, streams
// VLEN natural-order addresses, then holds until the FFT reports completion.
module dit_rd_seq
  import dit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bank_full_i,
  input  logic                 oldest_i,
  input  logic                 fft_ready_i,
  input  logic                 fft_done_i,
  output logic                 fft_start_o,
  output logic                 store_re_o,
  output logic                 store_rbank_o,
  output logic [VLEN_LOG2-1:0] store_raddr_o,
  output logic                 free_o,
  output rd_state_e            state_o
);

  rd_state_e            state_q, state_d;
  logic [VLEN_LOG2-1:0] cnt_q, cnt_d;

  // fft_ready only matters in IDLE and fft_done only in WAIT_DONE; both are
  // ignored everywhere else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    free_o  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (bank_full_i && fft_ready_i) begin
          state_d = RD_START;
        end
      end
      RD_START: begin
        state_d = RD_STREAM;
        cnt_d   = '0;
      end
      RD_STREAM: begin
        if (cnt_q == VLEN_LOG2'(VLEN - 1)) begin
          state_d = RD_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_WAIT_DONE: begin
        if (fft_done_i) begin
          free_o  = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fft_start_o   = (state_q == RD_START);
  assign store_re_o    = (state_q == RD_STREAM);
  assign store_raddr_o = store_re_o ? cnt_q : '0;
  assign store_rbank_o = ((state_q == RD_START) || (state_q == RD_STREAM)) ? oldest_i : 1'b0;
  assign state_o       = state_q;

endmodule

// File: rtl/dit_frame_ctrl.sv
// Ping-pong frame capture into a bit-reversed sample store, bank ownership
// tracking, drop accounting, and the FFT read sequencer.
module dit_frame_ctrl
  import dit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_valid,
  input  logic [DATLEN-1:0]    adc_data,
  input  logic                 fft_ready,
  input  logic                 fft_done,
  output logic                 store_we,
  output logic                 store_wbank,
  output logic [VLEN_LOG2-1:0] store_waddr,
  output logic [DATLEN-1:0]    store_wdata,
  output logic                 store_re,
  output logic                 store_rbank,
  output logic [VLEN_LOG2-1:0] store_raddr,
  output logic                 fft_start,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  logic [1:0]           full_q, full_d, full_eff;
  logic [VLEN_LOG2-1:0] wr_idx_q, wr_idx_d;
  logic                 wbank_q, wbank_d;
  logic                 oldest_q, oldest_d;
  logic                 we_q, we_d;
  logic                 wsel_q, wsel_d;
  logic [VLEN_LOG2-1:0] waddr_q, waddr_d;
  logic [DATLEN-1:0]    wdata_q, wdata_d;
  logic [15:0]          drop_q, drop_d;

  logic                 accept;
  logic                 drop;
  logic                 rd_free;
  logic                 rd_full;
  rd_state_e            rd_state;

  assign rd_full = full_q[oldest_q];

  dit_rd_seq u_rd_seq (
    .clk           (clk),
    .rst           (rst),
    .bank_full_i   (rd_full),
    .oldest_i      (oldest_q),
    .fft_ready_i   (fft_ready),
    .fft_done_i    (fft_done),
    .fft_start_o   (fft_start),
    .store_re_o    (store_re),
    .store_rbank_o (store_rbank),
    .store_raddr_o (store_raddr),
    .free_o        (rd_free),
    .state_o       (rd_state)
  );

  // A bank released this cycle is already writable, so a sample arriving with
  // the release lands at address 0 of that bank instead of being dropped.
  always_comb begin
    full_eff = full_q;
    if (rd_free) begin
      full_eff[oldest_q] = 1'b0;
    end
    accept = adc_valid && !full_eff[wbank_q];
    drop   = adc_valid &&  full_eff[wbank_q];

    full_d   = full_eff;
    wr_idx_d = wr_idx_q;
    wbank_d  = wbank_q;
    oldest_d = rd_free ? ~oldest_q : oldest_q;
    we_d     = accept;
    wsel_d   = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    drop_d   = drop_q;

    if (accept) begin
      wsel_d  = wbank_q;
      waddr_d = bitrev(wr_idx_q);
      wdata_d = adc_data;
      if (wr_idx_q == VLEN_LOG2'(VLEN - 1)) begin
        full_d[wbank_q] = 1'b1;
        wr_idx_d        = '0;
        wbank_d         = ~wbank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_idx_q <= '0;
      wbank_q  <= 1'b0;
      oldest_q <= 1'b0;
      we_q     <= 1'b0;
      wsel_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      drop_q   <= '0;
    end else begin
      full_q   <= full_d;
      wr_idx_q <= wr_idx_d;
      wbank_q  <= wbank_d;
      oldest_q <= oldest_d;
      we_q     <= we_d;
      wsel_q   <= wsel_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      drop_q   <= drop_d;
    end
  end

  assign store_we    = we_q;
  assign store_wbank = wsel_q;
  assign store_waddr = waddr_q;
  assign store_wdata = wdata_q;
  assign drop_cnt    = drop_q;
  assign busy        = (rd_state != RD_IDLE);

endmodule

// File: doc/dit_frame_ctrl.md
Name: dit_frame_ctrl

Overview:
- Frame scheduler between the ADC sample stream and the FFT core.
- Captures 16-sample frames into a two-bank (ping-pong) decimation-in-time sample store. Write addresses are bit-reversed, so the FFT reads each bank in natural order.
- Arbitrates the store between the capture side and the FFT read side. Issues the FFT start/stream sequence and counts samples dropped when both banks are occupied.

Parameters:
- DATLEN, 12, ADC sample width in bits.
- VLEN, 16, FFT frame length in samples.
- VLEN_LOG2, 4, log2(VLEN); width of store addresses.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- adc_valid  in  1  one-cycle strobe: adc_data holds a new sample.
- adc_data  in  DATLEN  sample value.
- fft_ready  in  1  FFT core idle and able to accept a frame.
- fft_done  in  1  one-cycle pulse: FFT finished consuming current frame.
- store_we  out  1  store write enable.
- store_wbank  out  1  bank being written.
- store_waddr  out  VLEN_LOG2  bit-reversed write address.
- store_wdata  out  DATLEN  write data.
- store_re  out  1  store read enable.
- store_rbank  out  1  bank being read.
- store_raddr  out  VLEN_LOG2  natural-order read address.
- fft_start  out  1  one-cycle pulse: frame stream begins next cycle.
- busy  out  1  read FSM not in IDLE.
- drop_cnt  out  16  saturating count of discarded samples.

Behaviour:
- Reset: all outputs 0.
  - Both banks empty; wr_idx = 0; write bank = 0; read FSM = IDLE.
  - An in-flight frame is discarded; drop_cnt cleared.
- Per-bank state: full flag. Frames are consumed in capture order.
  - A 1-bit oldest pointer selects the bank read next.
- Capture side:
  - On adc_valid with the current write bank not full: next cycle store_we=1, store_waddr=bitrev(wr_idx), store_wdata=adc_data.
  - Registered path, so latency is 1 cycle. wr_idx then increments.
- Frame completion: when wr_idx=VLEN-1 is accepted, the bank is marked full, wr_idx wraps to 0, and the write bank toggles to the other bank.
- Bank unavailable: if the target write bank is full, accepted samples are dropped.
  - store_we stays 0; drop_cnt increments by 1 per sample.
  - drop_cnt saturates at 16'hFFFF.
- Frame alignment: capture always restarts at wr_idx=0 of a freed bank. A partial frame is never mixed with dropped samples.
- Read FSM states: IDLE, START, STREAM, WAIT_DONE.
  - IDLE -> START: when the oldest bank is full and fft_ready=1.
  - START: fft_start=1 for exactly one cycle; store_rbank = oldest bank. -> STREAM.
  - STREAM: store_re=1 for VLEN consecutive cycles, store_raddr 0..VLEN-1. After the last address -> WAIT_DONE.
  - WAIT_DONE: on fft_done, clear that bank's full flag, toggle oldest -> IDLE.
- fft_done in any other state is ignored. fft_ready is sampled only in IDLE.
- Simultaneous events:
  - fft_done freeing the bank that capture is blocked on, in the same cycle as adc_valid: the free takes effect first, so that sample is written (wr_idx 0), not dropped.
  - Write and read never target the same bank in the same cycle. A bank being read is full by construction.
- busy = (state != IDLE).

Decomposition:
- Package dit_pkg: DATLEN, VLEN, VLEN_LOG2 constants; read-FSM state enum; bitrev(VLEN_LOG2-bit) function.
- One sub-module: dit_rd_seq (read FSM plus stream address counter). The capture and bank-flag logic stay in the top level.

Test Plan:
- Single frame: samples 0..15 on consecutive cycles, fft_ready=1.
  - store_waddr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, bank 0.
  - fft_start 1 cycle after the frame completes; store_raddr 0..15 on bank 0 over 16 cycles.
- Back-to-back frames with fft_ready=0: 40 samples.
  - Banks 0 and 1 full; samples 33..40 dropped, drop_cnt=8.
  - Then fft_ready=1 reads bank 0 first, then bank 1.
- Both banks full, then fft_done in the same cycle as adc_valid: that sample is written to the freed bank at waddr 0; drop_cnt unchanged.
- rst asserted during STREAM at raddr=7: next cycle all outputs 0.
  - No fft_start until 16 new samples have been captured.
- Stray fft_done in IDLE and STREAM: no state change; frame still streams all 16 addresses.
- Saturation: force 65540 drops; drop_cnt holds at 16'hFFFF.
